// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream, register-file and TX FIFO signals of uart_cmd_decoder.
// master = the decoder, slave = RX synchronizer / register file / TX FIFO side.
interface uart_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;
    logic                  FIFO_FULL;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  FRAME_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, FIFO_FULL,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, FIFO_FULL,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses 0xAA (write) / 0xBB (read) UART command frames into register-file and TX FIFO strobes.
// Optional macro CMD_TIMEOUT_EN aborts frames idle for TIMEOUT_CYCLES cycles.
module uart_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    uart_cmd_decoder_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  ferr_q, ferr_d;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == OP_WR)      state_d = WR_ADDR;
                    else if (bus.RX_P_DATA == OP_RD) state_d = RD_ADDR;
                    else                             ferr_d  = 1'b1;
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                ferr_d = bus.RX_D_VLD;
                if (bus.RdData_Valid) begin
                    tx_data_d = bus.RdData;
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                // An overrun byte still pulses FRAME_ERR even on the cycle the TX strobe goes out.
                ferr_d = bus.RX_D_VLD;
                if (!bus.FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Byte-consuming states always change state, so "no state change" means no accepted byte.
        cnt_d = '0;
        if ((state_q == WR_ADDR || state_q == WR_DATA || state_q == RD_ADDR ||
             state_q == RD_WAIT) && state_d == state_q) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_vld_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_vld_q  <= tx_vld_d;
            ferr_q    <= ferr_d;
`ifdef CMD_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.FRAME_ERR = ferr_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized frame-level bench for uart_cmd_decoder with a register-file array model.
// Timeout scenario runs only when CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16).
module tb_uart_cmd_decoder;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TMO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_cmd_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_cmd_decoder #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Register-file contents as seen by the bench (external to the DUT, so reset does not clear it).
    logic [DW-1:0] mem [16];
    int exp_wr = 0, exp_rd = 0, exp_tx = 0, exp_ferr = 0;
    int n_wr = 0, n_rd = 0, n_tx = 0, n_ferr = 0, n_both = 0;

    always @(negedge CLK) begin
        if (bus.WrEn)              n_wr++;
        if (bus.RdEn)              n_rd++;
        if (bus.TX_D_VLD)          n_tx++;
        if (bus.FRAME_ERR)         n_ferr++;
        if (bus.WrEn && bus.RdEn)  n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        step();
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            bus.RdData_Valid = noise ? 1'($urandom) : 1'b0;
            bus.RdData       = 8'($urandom);
            step();
        end
        bus.RdData_Valid = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input int g, input bit trail);
        send_byte(8'hAA);
        check("wr_op_ferr", bus.FRAME_ERR, 0);
        idle(g, 1'b1);
        send_byte(a);
        check("wr_addr_no_we", bus.WrEn, 0);
        idle(g, 1'b1);
        send_byte(d);
        check("wr_en", bus.WrEn, 1);
        check("wr_addr", bus.Address, a & 8'h0F);
        check("wr_data", bus.WrData, d);
        check("wr_no_rden", bus.RdEn, 0);
        check("wr_ferr", bus.FRAME_ERR, 0);
        mem[a[3:0]] = d;
        exp_wr++;
        if (trail) begin
            step();
            check("wr_en_one_cycle", bus.WrEn, 0);
        end
    endtask

    task automatic read_frame(input logic [7:0] a, input int g, input bit ovr,
                              input int nfull, input bit trail);
        logic [7:0] exp;
        send_byte(8'hBB);
        check("rd_op_ferr", bus.FRAME_ERR, 0);
        idle(g, 1'b0);
        send_byte(a);
        check("rd_en", bus.RdEn, 1);
        check("rd_addr", bus.Address, a & 8'h0F);
        check("rd_no_we", bus.WrEn, 0);
        exp_rd++;
        exp = mem[a[3:0]];
        idle(g, 1'b0);
        if (ovr) begin
            send_byte(8'($urandom));
            check("rd_wait_ovr_ferr", bus.FRAME_ERR, 1);
            exp_ferr++;
        end
        bus.RdData       = exp;
        bus.RdData_Valid = 1'b1;
        bus.FIFO_FULL    = (nfull > 0);
        step();
        bus.RdData_Valid = 1'b0;
        bus.RdData       = 8'($urandom);
        check("tx_not_yet", bus.TX_D_VLD, 0);
        check("tx_captured", bus.TX_P_DATA, exp);
        for (int i = 0; i < nfull; i++) begin
            if (ovr && i == 0) begin
                bus.RX_P_DATA = 8'($urandom);
                bus.RX_D_VLD  = 1'b1;
            end
            step();
            bus.RX_D_VLD = 1'b0;
            if (ovr && i == 0) begin
                check("tx_send_ovr_ferr", bus.FRAME_ERR, 1);
                exp_ferr++;
            end
            check("tx_hold_vld", bus.TX_D_VLD, 0);
            check("tx_hold_data", bus.TX_P_DATA, exp);
        end
        bus.FIFO_FULL = 1'b0;
        step();
        check("tx_vld", bus.TX_D_VLD, 1);
        check("tx_data", bus.TX_P_DATA, exp);
        exp_tx++;
        if (trail) begin
            step();
            check("tx_vld_one_cycle", bus.TX_D_VLD, 0);
        end
    endtask

    task automatic bad_opcode();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'hAA || b == 8'hBB) b = 8'($urandom);
        send_byte(b);
        check("bad_op_ferr", bus.FRAME_ERR, 1);
        check("bad_op_no_we", bus.WrEn, 0);
        exp_ferr++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"},  bus.WrEn, 0);
        check({tag, "_rden"},  bus.RdEn, 0);
        check({tag, "_addr"},  bus.Address, 0);
        check({tag, "_wdata"}, bus.WrData, 0);
        check({tag, "_txd"},   bus.TX_P_DATA, 0);
        check({tag, "_txv"},   bus.TX_D_VLD, 0);
        check({tag, "_ferr"},  bus.FRAME_ERR, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        bus.RX_P_DATA    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.FIFO_FULL    = 1'b0;

        step();
        step();
        check_outputs_zero("reset");
        RST = 1'b0;
        step();

        // Directed frames
        write_frame(8'h05, 8'h3C, 0, 1'b1);
        read_frame(8'h05, 0, 1'b0, 0, 1'b1);
        check("rd_back_literal", bus.TX_P_DATA, 8'h3C);
        read_frame(8'h05, 1, 1'b0, 10, 1'b1);
        send_byte(8'h12);
        check("bad_0x12_ferr", bus.FRAME_ERR, 1);
        exp_ferr++;
        step();
        check("ferr_one_cycle", bus.FRAME_ERR, 0);
        write_frame(8'h1F, 8'h01, 0, 1'b1);
        check("addr_truncated", bus.Address, 4'hF);
        read_frame(8'h1F, 2, 1'b1, 0, 1'b1);

        // Reset in WR_DATA aborts the frame
        send_byte(8'hAA);
        send_byte(8'h07);
        #2;
        RST = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send_byte(8'h3C);
        check("post_reset_no_we", bus.WrEn, 0);
        check("post_reset_ferr", bus.FRAME_ERR, 1);
        exp_ferr++;
        step();

`ifdef CMD_TIMEOUT_EN
        send_byte(8'hAA);
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            check("tmo_early_ferr", bus.FRAME_ERR, 0);
        end
        step();
        check("tmo_ferr", bus.FRAME_ERR, 1);
        check("tmo_no_we", bus.WrEn, 0);
        exp_ferr++;
        write_frame(8'h0A, 8'h5A, 0, 1'b1);
`endif

        // Randomized mix, including back-to-back frames when trail = 0
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: write_frame(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom));
                2:    read_frame(8'($urandom), $urandom_range(0, 3), 1'($urandom),
                                 $urandom_range(0, 5), 1'($urandom));
                default: bad_opcode();
            endcase
        end
        step();
        step();

        check("count_wr", n_wr, exp_wr);
        check("count_rd", n_rd, exp_rd);
        check("count_tx", n_tx, exp_tx);
        check("count_ferr", n_ferr, exp_ferr);
        check("wr_rd_overlap", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Single-clock command decoder directly downstream of the UART receiver. It consumes received bytes (parallel data plus valid strobe) and parses write/read command frames. It drives a register-file write/read interface and pushes read-back bytes toward the TX FIFO. It sits between the RX data synchronizer and the register file / TX FIFO write port.

Parameters:
DATA_WIDTH, 8, width of RX bytes, register data and TX bytes
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
TIMEOUT_CYCLES, 1024, idle-cycle limit inside a frame (used only with CMD_TIMEOUT_EN)

Ports:
CLK  in  1  single system clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1
RX_D_VLD  in  1  one-cycle strobe per received byte
RdData  in  DATA_WIDTH  register-file read data
RdData_Valid  in  1  register-file read data valid strobe
FIFO_FULL  in  1  TX FIFO full flag
WrEn  out  1  register write strobe, one cycle
RdEn  out  1  register read strobe, one cycle
Address  out  ADDR_WIDTH  register address
WrData  out  DATA_WIDTH  register write data
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe, one cycle
FRAME_ERR  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async, RST=1): state IDLE; WrEn, RdEn, TX_D_VLD, FRAME_ERR = 0; Address, WrData, TX_P_DATA = 0. Reset mid-frame aborts the frame; no partial write/read is issued.
- All outputs registered. A strobe appears on the cycle after the triggering input edge (latency 1).
- Opcodes: 0xAA = write frame (opcode, addr, data). 0xBB = read frame (opcode, addr).
- States and transitions:
  IDLE: on RX_D_VLD, 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> stay IDLE, FRAME_ERR pulse.
  WR_ADDR: on RX_D_VLD, latch Address = byte[ADDR_WIDTH-1:0] -> WR_DATA. Upper address bits are ignored silently.
  WR_DATA: on RX_D_VLD, WrData = byte, WrEn = 1 for one cycle -> IDLE.
  RD_ADDR: on RX_D_VLD, latch Address, RdEn = 1 for one cycle -> RD_WAIT.
  RD_WAIT: on RdData_Valid, capture RdData into TX_P_DATA -> TX_SEND. RdData_Valid in any other state is ignored.
  TX_SEND: if FIFO_FULL=0, TX_D_VLD = 1 for one cycle -> IDLE. If FIFO_FULL=1, hold with TX_P_DATA stable and no strobe.
- RX_D_VLD during RD_WAIT or TX_SEND: byte discarded, FRAME_ERR pulse, state unchanged. This includes the cycle TX_D_VLD is issued.
- Address and WrData hold their last values between frames. WrEn and RdEn are never both high.
- Back-to-back frames: a new opcode is accepted in the cycle immediately after returning to IDLE.
- Without the optional feature, a frame waits indefinitely in any non-IDLE state.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: a counter clears on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT and on every accepted byte, and increments each cycle in those states. On reaching TIMEOUT_CYCLES, state -> IDLE with a FRAME_ERR pulse; no WrEn/RdEn is issued. TX_SEND is exempt because FIFO backpressure is legal.
- Undefined: no counter; states wait indefinitely.

Test Plan:
- Write: bytes 0xAA, 0x05, 0x3C -> one cycle later WrEn=1, Address=5, WrData=0x3C; RdEn=0, FRAME_ERR=0.
- Read: 0xBB, 0x05, then RdData=0x3C with RdData_Valid -> RdEn pulse with Address=5; next TX_D_VLD=1, TX_P_DATA=0x3C.
- Backpressure: read frame with FIFO_FULL=1 for 10 cycles -> no TX_D_VLD while full; single TX_D_VLD on the cycle after FIFO_FULL falls.
- Bad opcode 0x12 -> FRAME_ERR pulse, state IDLE; a following 0xAA,0x1F,0x01 -> WrEn with Address=0xF (truncated).
- Overrun and reset: byte arrives in RD_WAIT -> FRAME_ERR, read completes normally. RST asserted in WR_DATA -> all outputs 0, and the next data byte causes no write.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0xAA then silence -> FRAME_ERR after 16 cycles, no WrEn; a subsequent full write frame succeeds.
